// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port data RAM arbiter.
// FSM states, port IDs and latency-counter width.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int CNT_W = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker: round-robin on a tie, or
// fixed priority (A first) when prio is set.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic       gnt,
  output logic       id
);

  always_comb begin
    gnt = |req;
    id  = PORT_A;
    unique case (req)
      2'b11:   id = prio ? PORT_A : ~last;
      2'b10:   id = PORT_B;
      default: id = PORT_A;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises CPU (A) and loader/DMA (B) accesses onto the
// single-port data RAM with req/ack and read-latency tracking.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              owner
);

  localparam logic [CNT_W-1:0] LAST_CNT =
    (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             we_q;
  logic             gnt, win;
  logic             load, cap;

  rr_pick2 u_pick (
    .req  ({b_req, a_req}),
    .last (owner),
    .prio (CPU_PRIO != 0),
    .gnt  (gnt),
    .id   (win)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (gnt) begin
          load    = 1'b1;
          state_n = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (we_q || RD_LAT == 1) begin
          state_n = ARB_DONE;
          cap     = ~we_q;
        end else begin
          state_n = ARB_WAIT;
          cnt_n   = '0;
        end
      end
      ARB_WAIT: begin
        if (cnt == LAST_CNT) begin
          state_n = ARB_DONE;
          cap     = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ARB_DONE: state_n = ARB_IDLE;
      default:  state_n = ARB_IDLE;
    endcase
  end

  // owner doubles as last_owner for the round-robin tie break
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      owner    <= PORT_B;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ram_we <= 1'b0;
      if (load) begin
        owner    <= win;
        we_q     <= win ? b_we : a_we;
        ram_we   <= win ? b_we : a_we;
        ram_addr <= win ? b_addr : a_addr;
        ram_din  <= win ? b_wdata : a_wdata;
      end
      if (cap && owner == PORT_A) a_rdata <= ram_dout;
      if (cap && owner == PORT_B) b_rdata <= ram_dout;
    end
  end

  assign busy  = (state != ARB_IDLE);
  assign a_ack = (state == ARB_DONE) && (owner == PORT_A);
  assign b_ack = (state == ARB_DONE) && (owner == PORT_B);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: instance 0 is RD_LAT=1 round-robin,
// instance 1 is RD_LAT=3 fixed priority.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        a_req    [2];
  logic        a_we     [2];
  logic [9:0]  a_addr   [2];
  logic [31:0] a_wdata  [2];
  logic        a_ack    [2];
  logic [31:0] a_rdata  [2];
  logic        b_req    [2];
  logic        b_we     [2];
  logic [9:0]  b_addr   [2];
  logic [31:0] b_wdata  [2];
  logic        b_ack    [2];
  logic [31:0] b_rdata  [2];
  logic [9:0]  ram_addr [2];
  logic        ram_we   [2];
  logic [31:0] ram_din  [2];
  logic [31:0] ram_dout [2];
  logic        busy     [2];
  logic        owner    [2];

  logic        ld_we;
  logic        ld_sel;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_arbiter #(
      .ADDR_W   (10),
      .DATA_W   (32),
      .RD_LAT   (g == 0 ? 1 : 3),
      .CPU_PRIO (g == 0 ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .a_req    (a_req[g]),
      .a_we     (a_we[g]),
      .a_addr   (a_addr[g]),
      .a_wdata  (a_wdata[g]),
      .a_ack    (a_ack[g]),
      .a_rdata  (a_rdata[g]),
      .b_req    (b_req[g]),
      .b_we     (b_we[g]),
      .b_addr   (b_addr[g]),
      .b_wdata  (b_wdata[g]),
      .b_ack    (b_ack[g]),
      .b_rdata  (b_rdata[g]),
      .ram_addr (ram_addr[g]),
      .ram_we   (ram_we[g]),
      .ram_din  (ram_din[g]),
      .ram_dout (ram_dout[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );

    logic [31:0] mem [1024];
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
      else if (ld_we && ld_sel == 1'(g)) mem[ld_addr] <= ld_data;
    end
    assign ram_dout[g] = mem[ram_addr[g]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_sat(input int d, input string tag);
    int   na, nb, ovl;
    logic seq [$];
    na = 0;
    nb = 0;
    ovl = 0;
    a_we[d] = 1'b1;
    b_we[d] = 1'b1;
    a_addr[d] = 10'h100;
    b_addr[d] = 10'h200;
    a_wdata[d] = 32'hA000_0000;
    b_wdata[d] = 32'hB000_0000;
    a_req[d] = 1'b1;
    b_req[d] = 1'b1;
    for (int c = 0; c < 200 && (na < 8 || nb < 8); c++) begin
      tick();
      if (a_ack[d] && b_ack[d]) ovl++;
      if (a_ack[d]) begin
        seq.push_back(1'b0);
        na++;
        if (na == 8) a_req[d] = 1'b0;
        a_addr[d] = 10'h100 + 10'(na);
        a_wdata[d] = 32'hA000_0000 + 32'(na);
      end
      if (b_ack[d]) begin
        seq.push_back(1'b1);
        nb++;
        if (nb == 8) b_req[d] = 1'b0;
        b_addr[d] = 10'h200 + 10'(nb);
        b_wdata[d] = 32'hB000_0000 + 32'(nb);
      end
    end
    tick();
    chk({tag, "_a_acks"}, na, 8);
    chk({tag, "_b_acks"}, nb, 8);
    chk({tag, "_overlap"}, ovl, 0);
    for (int k = 0; k < 16 && k < seq.size(); k++)
      chk($sformatf("%s_order%0d", tag, k), 32'(seq[k]),
          d == 0 ? 32'(k % 2) : (k < 8 ? 32'd0 : 32'd1));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      a_req[i] = 1'b0;
      a_we[i] = 1'b0;
      a_addr[i] = '0;
      a_wdata[i] = '0;
      b_req[i] = 1'b0;
      b_we[i] = 1'b0;
      b_addr[i] = '0;
      b_wdata[i] = '0;
    end
    ld_we = 1'b1;
    ld_sel = 1'b1;
    ld_addr = 10'h3FF;
    ld_data = 32'h1234_5678;
    tick();
    ld_sel = 1'b0;
    ld_addr = 10'h006;
    ld_data = 32'hCAFE_0006;
    tick();
    ld_we = 1'b0;

    chk("rst_busy", busy[0], 1'b0);
    chk("rst_we", ram_we[0], 1'b0);
    chk("rst_aack", a_ack[0], 1'b0);
    chk("rst_back", b_ack[0], 1'b0);
    chk("rst_addr", ram_addr[0], 0);
    chk("rst_din", ram_din[0], 0);
    chk("rst_ardata", a_rdata[0], 0);
    chk("rst_brdata", b_rdata[0], 0);
    chk("rst_owner", owner[0], 1'b1);
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    // A write then read back on instance 0
    a_req[0] = 1'b1;
    a_we[0] = 1'b1;
    a_addr[0] = 10'h005;
    a_wdata[0] = 32'hDEAD_BEEF;
    tick();
    chk("wr_acc_we", ram_we[0], 1'b1);
    chk("wr_acc_addr", ram_addr[0], 10'h005);
    chk("wr_acc_din", ram_din[0], 32'hDEAD_BEEF);
    chk("wr_acc_owner", owner[0], 1'b0);
    chk("wr_acc_ack", a_ack[0], 1'b0);
    tick();
    chk("wr_done_we", ram_we[0], 1'b0);
    chk("wr_done_ack", a_ack[0], 1'b1);
    a_req[0] = 1'b0;
    tick();
    chk("wr_idle_ack", a_ack[0], 1'b0);
    chk("wr_idle_busy", busy[0], 1'b0);
    a_req[0] = 1'b1;
    a_we[0] = 1'b0;
    tick();
    chk("rd_acc_we", ram_we[0], 1'b0);
    chk("rd_acc_ack", a_ack[0], 1'b0);
    tick();
    chk("rd_ack", a_ack[0], 1'b1);
    chk("rd_ardata", a_rdata[0], 32'hDEAD_BEEF);
    chk("rd_brdata", b_rdata[0], 0);
    a_req[0] = 1'b0;
    tick();

    // simultaneous reads right after reset
    rst[0] = 1'b0;
    tick();
    chk("rst2_owner", owner[0], 1'b1);
    rst[0] = 1'b1;
    a_req[0] = 1'b1;
    b_req[0] = 1'b1;
    b_we[0] = 1'b0;
    b_addr[0] = 10'h006;
    tick();
    chk("tie_owner_a", owner[0], 1'b0);
    tick();
    chk("tie_aack", a_ack[0], 1'b1);
    chk("tie_back0", b_ack[0], 1'b0);
    chk("tie_ardata", a_rdata[0], 32'hDEAD_BEEF);
    a_req[0] = 1'b0;
    tick();
    chk("tie_gap_a", a_ack[0], 1'b0);
    chk("tie_gap_b", b_ack[0], 1'b0);
    tick();
    chk("tie_owner_b", owner[0], 1'b1);
    tick();
    chk("tie_back", b_ack[0], 1'b1);
    chk("tie_aack0", a_ack[0], 1'b0);
    chk("tie_brdata", b_rdata[0], 32'hCAFE_0006);
    b_req[0] = 1'b0;
    tick();

    run_sat(0, "rr");
    chk("rr_mem", g_dut[0].mem[10'h107], 32'hA000_0007);

    // A arrives while B's write is in ACCESS
    b_req[0] = 1'b1;
    b_we[0] = 1'b1;
    b_addr[0] = 10'h050;
    b_wdata[0] = 32'h0000_0050;
    tick();
    chk("late_owner_b", owner[0], 1'b1);
    chk("late_addr_b", ram_addr[0], 10'h050);
    a_req[0] = 1'b1;
    a_we[0] = 1'b0;
    a_addr[0] = 10'h005;
    tick();
    chk("late_back", b_ack[0], 1'b1);
    chk("late_addr_hold", ram_addr[0], 10'h050);
    b_req[0] = 1'b0;
    tick();
    chk("late_idle_busy", busy[0], 1'b0);
    chk("late_idle_aack", a_ack[0], 1'b0);
    tick();
    chk("late_owner_a", owner[0], 1'b0);
    chk("late_addr_a", ram_addr[0], 10'h005);
    tick();
    chk("late_aack", a_ack[0], 1'b1);
    a_req[0] = 1'b0;
    tick();

    // RD_LAT=3 read from B on instance 1
    b_req[1] = 1'b1;
    b_we[1] = 1'b0;
    b_addr[1] = 10'h3FF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("l3_busy%0d", c), busy[1], 1'b1);
      chk($sformatf("l3_back%0d", c), b_ack[1], c == 4);
    end
    chk("l3_brdata", b_rdata[1], 32'h1234_5678);
    b_req[1] = 1'b0;
    tick();
    chk("l3_busy_end", busy[1], 1'b0);

    a_req[1] = 1'b1;
    a_we[1] = 1'b0;
    a_addr[1] = 10'h3FF;
    tick();
    tick();
    tick();
    chk("l3a_early", a_ack[1], 1'b0);
    tick();
    chk("l3a_ack", a_ack[1], 1'b1);
    chk("l3a_rdata", a_rdata[1], 32'h1234_5678);
    a_req[1] = 1'b0;
    tick();

    // reset during WAIT of an A read
    a_req[1] = 1'b1;
    tick();
    tick();
    chk("ab_wait_busy", busy[1], 1'b1);
    rst[1] = 1'b0;
    a_req[1] = 1'b0;
    tick();
    chk("ab_busy", busy[1], 1'b0);
    chk("ab_aack", a_ack[1], 1'b0);
    chk("ab_ardata", a_rdata[1], 0);
    chk("ab_owner", owner[1], 1'b1);
    rst[1] = 1'b1;
    tick();
    chk("ab_aack2", a_ack[1], 1'b0);
    b_req[1] = 1'b1;
    tick();
    chk("ab_b_owner", owner[1], 1'b1);
    tick();
    tick();
    tick();
    chk("ab_back", b_ack[1], 1'b1);
    chk("ab_brdata", b_rdata[1], 32'h1234_5678);
    b_req[1] = 1'b0;
    tick();

    run_sat(1, "prio");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
